core_memory: RTL

- Memory stage of the five-stage core. Sits directly downstream of execute and consumes its m_if (alu_out, rs2, control).
- Performs loads/stores over a single-outstanding req/ack data bus and selects the writeback value.
- Presents results to writeback on w_if with a valid/ready handshake.
- Only pipeline stage with variable latency; stalls execute via m.ready.

---
 rtl/core_mem_pkg.sv | 25 ++
 rtl/core_mem_if.sv | 53 +++++
 rtl/core_lsu_align.sv | 60 ++++++
 rtl/core_memory.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/core_mem_pkg.sv
// Shared types for the memory stage: load/store widths, writeback select and FSM state.
package core_mem_pkg;

  // funct3 encoding of the access width / signedness
  typedef enum logic [2:0] {
    MT_B  = 3'b000,
    MT_H  = 3'b001,
    MT_W  = 3'b010,
    MT_BU = 3'b100,
    MT_HU = 3'b101
  } mem_type_e;

  typedef enum logic [1:0] {
    WSEL_ALU = 2'd0,
    WSEL_MEM = 2'd1,
    WSEL_PC4 = 2'd2,
    WSEL_IMM = 2'd3
  } reg_wsel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_e;

endpackage

// File: rtl/core_mem_if.sv
// Pipeline interfaces around the memory stage.
// m_if.master is the view held by the memory stage: it consumes the execute
// results and drives ready back. w_if.master drives writeback.
interface m_if
  import core_mem_pkg::*;
#(
  parameter int XLEN = 32
) ();
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs2;
  logic [4:0]      rd;
  logic            reg_wen;
  reg_wsel_e       reg_wsel;
  logic [XLEN-1:0] alu_out;
  mem_type_e       mem_type;
  logic            mem_ren;
  logic            mem_wen;
  logic            valid;
  logic            ready;

  modport master (
    input  pc, imm, rs2, rd, reg_wen, reg_wsel, alu_out,
    input  mem_type, mem_ren, mem_wen, valid,
    output ready
  );

  modport slave (
    output pc, imm, rs2, rd, reg_wen, reg_wsel, alu_out,
    output mem_type, mem_ren, mem_wen, valid,
    input  ready
  );
endinterface

interface w_if #(
  parameter int XLEN = 32
) ();
  logic [4:0]      rd;
  logic            reg_wen;
  logic [XLEN-1:0] wdata;
  logic            valid;
  logic            ready;

  modport master (
    output rd, reg_wen, wdata, valid,
    input  ready
  );

  modport slave (
    input  rd, reg_wen, wdata, valid,
    output ready
  );
endinterface

// File: rtl/core_lsu_align.sv
// Byte-lane steering for loads and stores: byte enables, replicated store
// data, extended load data and misalignment detection. Purely combinational.
module core_lsu_align
  import core_mem_pkg::*;
(
  input  logic [1:0]  addr,
  input  mem_type_e   mem_type,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = 8'(rdata >> {addr, 3'b000});
  assign half_v = 16'(rdata >> {addr[1], 4'b0000});

  // Decode width into lane enables and extension; unknown encodings act as word
  always_comb begin
    be         = 4'b1111;
    wdata      = rs2;
    load_data  = rdata;
    misaligned = 1'b0;
    case (mem_type)
      MT_B: begin
        be        = 4'b0001 << addr;
        wdata     = {4{rs2[7:0]}};
        load_data = {{24{byte_v[7]}}, byte_v};
      end
      MT_BU: begin
        be        = 4'b0001 << addr;
        wdata     = {4{rs2[7:0]}};
        load_data = {24'd0, byte_v};
      end
      MT_H: begin
        be         = 4'b0011 << {addr[1], 1'b0};
        wdata      = {2{rs2[15:0]}};
        load_data  = {{16{half_v[15]}}, half_v};
        misaligned = addr[0];
      end
      MT_HU: begin
        be         = 4'b0011 << {addr[1], 1'b0};
        wdata      = {2{rs2[15:0]}};
        load_data  = {16'd0, half_v};
        misaligned = addr[0];
      end
      default: begin
        be         = 4'b1111;
        wdata      = rs2;
        load_data  = rdata;
        misaligned = |addr;
      end
    endcase
  end

endmodule

// File: rtl/core_memory.sv
// Memory stage: issues single-outstanding data bus transactions and
// presents the writeback value on w_if with valid/ready.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for a new op from execute (if the writeback slot frees)
//   BUS   | dmem_req held with stable request fields until dmem_ack
module core_memory
  import core_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  m_if.master             m,
  w_if.master             w,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            misalign_err
);

  state_e          state;
  logic            w_valid;
  logic [4:0]      w_rd;
  logic            w_reg_wen;
  logic [XLEN-1:0] w_wdata;

  // Attributes of the in-flight bus op, kept apart from the w slot so
  // the previous result can drain while the bus is busy.
  logic            p_load;
  logic [4:0]      p_rd;
  logic            p_reg_wen;
  mem_type_e       p_type;
  logic [1:0]      p_off;

  logic            accept;
  logic            is_mem;
  logic [1:0]      sel_off;
  mem_type_e       sel_type;
  logic [3:0]      al_be;
  logic [31:0]     al_wdata;
  logic [31:0]     al_load;
  logic            al_mis;
  logic [XLEN-1:0] alu_wb;

  assign m.ready = (state == IDLE) & (~w_valid | w.ready);
  assign accept  = m.valid & m.ready;
  assign is_mem  = m.mem_ren | m.mem_wen;

  assign w.valid   = w_valid;
  assign w.rd      = w_rd;
  assign w.reg_wen = w_reg_wen;
  assign w.wdata   = w_wdata;

  // Align unit sees the incoming op in IDLE and the held op in BUS
  assign sel_off  = (state == BUS) ? p_off  : m.alu_out[1:0];
  assign sel_type = (state == BUS) ? p_type : m.mem_type;

  core_lsu_align u_align (
    .addr       (sel_off),
    .mem_type   (sel_type),
    .rs2        (m.rs2),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_mis)
  );

  // Writeback value for non-memory ops
  always_comb begin
    alu_wb = m.alu_out;
    case (m.reg_wsel)
      WSEL_PC4: alu_wb = m.pc + XLEN'(4);
      WSEL_IMM: alu_wb = m.imm;
      default:  alu_wb = m.alu_out;
    endcase
  end

  // Stage FSM with registered bus, writeback and error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      w_valid      <= 1'b0;
      w_rd         <= '0;
      w_reg_wen    <= 1'b0;
      w_wdata      <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      misalign_err <= 1'b0;
      p_load       <= 1'b0;
      p_rd         <= '0;
      p_reg_wen    <= 1'b0;
      p_type       <= MT_W;
      p_off        <= '0;
    end else begin
      misalign_err <= 1'b0;
      if (w_valid && w.ready) begin
        w_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              w_valid   <= 1'b1;
              w_rd      <= m.rd;
              w_reg_wen <= m.reg_wen;
              w_wdata   <= alu_wb;
            end else if (al_mis) begin
              misalign_err <= 1'b1;
              w_valid      <= 1'b1;
              w_rd         <= m.rd;
              w_reg_wen    <= 1'b0;
              w_wdata      <= '0;
            end else begin
              state      <= BUS;
              dmem_req   <= 1'b1;
              dmem_we    <= m.mem_wen;
              dmem_addr  <= {m.alu_out[XLEN-1:2], 2'b00};
              dmem_be    <= al_be;
              dmem_wdata <= al_wdata;
              p_load     <= ~m.mem_wen;
              p_rd       <= m.rd;
              p_reg_wen  <= m.reg_wen;
              p_type     <= m.mem_type;
              p_off      <= m.alu_out[1:0];
            end
          end
        end
        BUS: begin
          if (dmem_ack) begin
            state     <= IDLE;
            dmem_req  <= 1'b0;
            w_valid   <= 1'b1;
            w_rd      <= p_rd;
            w_reg_wen <= p_load & p_reg_wen;
            w_wdata   <= p_load ? al_load : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
